// File: rtl/goomba_sprite_fetch.sv
// goomba_sprite_fetch: maps the VGA beam onto the goomba bounding box and drives
// the shared walk-frame ROM address. It registers the returned color and runs
// the walk / squash / gone life cycle.
// Optional build macro GOOMBA_MIRROR_EN adds a face_left input. When face_left
// is sampled high on a frame_tick, the sprite is drawn horizontally mirrored.
module goomba_sprite_fetch #(
  parameter int          SPR_W         = 20,
  parameter int          SPR_H         = 22,
  parameter int          ANIM_FRAMES   = 8,
  parameter int          SQUASH_FRAMES = 30,
  parameter logic [11:0] TRANSP_KEY    = 12'h808
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_tick,
  input  logic        pix_en,
  input  logic [9:0]  draw_x,
  input  logic [9:0]  draw_y,
  input  logic [9:0]  goomba_x,
  input  logic [9:0]  goomba_y,
  input  logic        active,
  input  logic        stomp,
`ifdef GOOMBA_MIRROR_EN
  input  logic        face_left,
`endif
  input  logic [11:0] walk1_color,
  input  logic [11:0] walk2_color,
  output logic [8:0]  rom_addr,
  output logic        frame_sel,
  output logic [11:0] pix_color,
  output logic        pix_valid,
  output logic        squashed,
  output logic        done
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WALK   = 2'd1;
  localparam logic [1:0] SQUASH = 2'd2;
  localparam logic [1:0] GONE   = 2'd3;

  localparam int ANIM_CW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
  localparam int SQ_CW   = (SQUASH_FRAMES > 1) ? $clog2(SQUASH_FRAMES) : 1;

  logic [1:0]         state;
  logic [ANIM_CW-1:0] anim_cnt;
  logic [SQ_CW-1:0]   sq_cnt;
  logic               frame_sel_r;
  logic               mirror;

  logic [10:0] col;
  logic [10:0] row;
  logic        in_box;
  logic        visible;
  logic        row_ok;

  logic [8:0]  rom_addr_p0;
  logic        vld_p0;
  logic        frame_sel_p0;
  logic [11:0] color_p1;
  logic        vld_p1;
  logic [11:0] rom_color;

  // Linear ROM address for a sprite pixel. The column is optionally reflected
  // so the same ROM image serves both facing directions.
  function automatic logic [8:0] sprite_addr(input logic [8:0] r,
                                             input logic [8:0] c,
                                             input logic       mir);
    logic [8:0] c_eff;
    c_eff = mir ? (9'(SPR_W - 1) - c) : c;
    return r * 9'(SPR_W) + c_eff;
  endfunction

  // Life-cycle FSM plus the walk-animation and squash counters; active=0 overrides everything
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      anim_cnt    <= '0;
      sq_cnt      <= '0;
      frame_sel_r <= 1'b0;
    end else if (!active) begin
      state       <= IDLE;
      anim_cnt    <= '0;
      sq_cnt      <= '0;
      frame_sel_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state       <= WALK;
          anim_cnt    <= '0;
          sq_cnt      <= '0;
          frame_sel_r <= 1'b0;
        end
        WALK: begin
          if (stomp) begin
            // A stomp beats a coincident frame_tick: the animation restarts from frame 0
            state       <= SQUASH;
            anim_cnt    <= '0;
            sq_cnt      <= '0;
            frame_sel_r <= 1'b0;
          end else if (frame_tick) begin
            if (anim_cnt == ANIM_CW'(ANIM_FRAMES - 1)) begin
              anim_cnt    <= '0;
              frame_sel_r <= ~frame_sel_r;
            end else begin
              anim_cnt <= anim_cnt + 1'b1;
            end
          end
        end
        SQUASH: begin
          frame_sel_r <= 1'b0;
          if (frame_tick) begin
            if (sq_cnt == SQ_CW'(SQUASH_FRAMES - 1)) begin
              state  <= GONE;
              sq_cnt <= '0;
            end else begin
              sq_cnt <= sq_cnt + 1'b1;
            end
          end
        end
        GONE: begin
          frame_sel_r <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          frame_sel_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef GOOMBA_MIRROR_EN
  // Facing direction only changes at frame boundaries so a frame is never torn
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mirror <= 1'b0;
    end else if (frame_tick) begin
      mirror <= face_left;
    end
  end
`else
  assign mirror = 1'b0;
`endif

  // Box test in 11-bit math so a beam left of / above the sprite never wraps into the box
  always_comb begin
    col     = {1'b0, draw_x} - {1'b0, goomba_x};
    row     = {1'b0, draw_y} - {1'b0, goomba_y};
    in_box  = (draw_x >= goomba_x) && (col < 11'(SPR_W)) &&
              (draw_y >= goomba_y) && (row < 11'(SPR_H));
    visible = (state == WALK) || (state == SQUASH);
    row_ok  = (state != SQUASH) || (row >= 11'(SPR_H / 2));
  end

  // ---- stage 0: ROM address and hit qualification ----
  // Register the ROM address together with the hit flag and frame select that belong to it
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr_p0  <= '0;
      vld_p0       <= 1'b0;
      frame_sel_p0 <= 1'b0;
    end else begin
      rom_addr_p0  <= in_box ? sprite_addr(row[8:0], col[8:0], mirror) : 9'd0;
      vld_p0       <= in_box & pix_en & visible & row_ok;
      frame_sel_p0 <= frame_sel_r;
    end
  end

  assign rom_color = frame_sel_p0 ? walk2_color : walk1_color;

  // ---- stage 1: ROM data capture and transparency keying ----
  // Register the selected ROM color; the key color suppresses the valid flag
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      color_p1 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      color_p1 <= rom_color;
      vld_p1   <= vld_p0 & (rom_color != TRANSP_KEY);
    end
  end

  assign rom_addr  = rom_addr_p0;
  assign frame_sel = frame_sel_r;
  assign pix_color = color_p1;
  assign pix_valid = vld_p1;
  assign squashed  = (state == SQUASH);
  assign done      = (state == GONE);

endmodule

// File: tb/tb_goomba_sprite_fetch.sv
// Directed bench for goomba_sprite_fetch: beam mapping, borders, transparency,
// animation, squash / gone sequencing and mid-stream reset.
module tb_goomba_sprite_fetch;

  logic        Clk;
  logic        Reset_n;
  logic        frame_tick;
  logic        pix_en;
  logic [9:0]  draw_x;
  logic [9:0]  draw_y;
  logic [9:0]  goomba_x;
  logic [9:0]  goomba_y;
  logic        active;
  logic        stomp;
  logic [11:0] walk1_color;
  logic [11:0] walk2_color;
  logic [8:0]  rom_addr;
  logic        frame_sel;
  logic [11:0] pix_color;
  logic        pix_valid;
  logic        squashed;
  logic        done;
`ifdef GOOMBA_MIRROR_EN
  logic        face_left;
`endif

  int n_cmp = 0;
  int n_err = 0;

  goomba_sprite_fetch dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_tick  (frame_tick),
    .pix_en      (pix_en),
    .draw_x      (draw_x),
    .draw_y      (draw_y),
    .goomba_x    (goomba_x),
    .goomba_y    (goomba_y),
    .active      (active),
    .stomp       (stomp),
`ifdef GOOMBA_MIRROR_EN
    .face_left   (face_left),
`endif
    .walk1_color (walk1_color),
    .walk2_color (walk2_color),
    .rom_addr    (rom_addr),
    .frame_sel   (frame_sel),
    .pix_color   (pix_color),
    .pix_valid   (pix_valid),
    .squashed    (squashed),
    .done        (done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
  endtask

  // One isolated pixel: address checked after 1 clock, color/valid after 2
  task automatic pix(input string tag, input logic [9:0] x, input logic [9:0] y,
                     input logic [8:0] ea, input logic ev, input logic [11:0] ec);
    draw_x = x;
    draw_y = y;
    pix_en = 1'b1;
    step();
    chk({tag, "_addr"}, 32'(rom_addr), 32'(ea));
    pix_en = 1'b0;
    step();
    chk({tag, "_valid"}, 32'(pix_valid), 32'(ev));
    chk({tag, "_color"}, 32'(pix_color), 32'(ec));
  endtask

  initial begin
    Reset_n     = 1'b0;
    frame_tick  = 1'b0;
    pix_en      = 1'b0;
    draw_x      = 10'd0;
    draw_y      = 10'd0;
    goomba_x    = 10'd100;
    goomba_y    = 10'd200;
    active      = 1'b0;
    stomp       = 1'b0;
    walk1_color = 12'hE51;
    walk2_color = 12'h123;
`ifdef GOOMBA_MIRROR_EN
    face_left   = 1'b0;
`endif
    step();
    step();
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_fsel", 32'(frame_sel), 32'd0);
    chk("rst_color", 32'(pix_color), 32'd0);
    chk("rst_valid", 32'(pix_valid), 32'd0);
    chk("rst_squashed", 32'(squashed), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    Reset_n = 1'b1;
    active  = 1'b1;
    step();

    // Walk frame 1, main mapping and borders
    pix("map", 10'd105, 10'd203, 9'd65, 1'b1, 12'hE51);
    pix("br_corner", 10'd119, 10'd221, 9'd439, 1'b1, 12'hE51);
    pix("br_right", 10'd120, 10'd221, 9'd0, 1'b0, 12'hE51);
    pix("br_left", 10'd99, 10'd210, 9'd0, 1'b0, 12'hE51);
    pix("br_below", 10'd110, 10'd222, 9'd0, 1'b0, 12'hE51);

    // Transparency key
    walk1_color = 12'h808;
    pix("transp", 10'd105, 10'd203, 9'd65, 1'b0, 12'h808);
    walk1_color = 12'hE51;

    // Animation: toggle on the 8th tick, back on the 16th
    for (int i = 0; i < 7; i++) tick();
    chk("anim_7", 32'(frame_sel), 32'd0);
    tick();
    chk("anim_8", 32'(frame_sel), 32'd1);
    pix("walk2", 10'd101, 10'd200, 9'd1, 1'b1, 12'h123);
    for (int i = 0; i < 8; i++) tick();
    chk("anim_16", 32'(frame_sel), 32'd0);
    for (int i = 0; i < 8; i++) tick();
    chk("anim_24", 32'(frame_sel), 32'd1);

    // Stomp coinciding with frame_tick
    stomp      = 1'b1;
    frame_tick = 1'b1;
    step();
    stomp      = 1'b0;
    frame_tick = 1'b0;
    chk("stomp_sq", 32'(squashed), 32'd1);
    chk("stomp_fsel", 32'(frame_sel), 32'd0);

    // Squash: only the lower half is drawn
    pix("sq_row5", 10'd105, 10'd205, 9'd105, 1'b0, 12'hE51);
    pix("sq_row15", 10'd105, 10'd215, 9'd305, 1'b1, 12'hE51);
    for (int i = 0; i < 29; i++) tick();
    chk("sq_29_done", 32'(done), 32'd0);
    chk("sq_29_sq", 32'(squashed), 32'd1);
    tick();
    chk("sq_30_done", 32'(done), 32'd1);
    chk("sq_30_sq", 32'(squashed), 32'd0);
    pix("gone", 10'd105, 10'd215, 9'd305, 1'b0, 12'hE51);
    tick();
    chk("gone_hold", 32'(done), 32'd1);

    // Deactivate: back to IDLE; stomp ignored there
    active = 1'b0;
    step();
    chk("idle_done", 32'(done), 32'd0);
    pix("idle_pix", 10'd105, 10'd215, 9'd305, 1'b0, 12'hE51);
    stomp = 1'b1;
    step();
    stomp = 1'b0;
    chk("idle_stomp", 32'(squashed), 32'd0);

    // active=0 outranks stomp in WALK
    active = 1'b1;
    step();
    active = 1'b0;
    stomp  = 1'b1;
    step();
    stomp  = 1'b0;
    chk("prio_stomp", 32'(squashed), 32'd0);
    active = 1'b1;
    step();
    stomp = 1'b1;
    step();
    stomp = 1'b0;
    chk("walk_stomp", 32'(squashed), 32'd1);
    active = 1'b0;
    step();
    active = 1'b1;
    step();

    // Mid-stream reset with the beam inside the box
    draw_x = 10'd105;
    draw_y = 10'd203;
    pix_en = 1'b1;
    step();
    step();
    chk("pre_rst_valid", 32'(pix_valid), 32'd1);
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(pix_valid), 32'd0);
    chk("mid_rst_addr", 32'(rom_addr), 32'd0);
    chk("mid_rst_color", 32'(pix_color), 32'd0);
    #1;
    Reset_n = 1'b1;
    step();
    chk("post_rst_1", 32'(pix_valid), 32'd0);
    step();
    chk("post_rst_2", 32'(pix_valid), 32'd0);
    step();
    chk("post_rst_3", 32'(pix_valid), 32'd1);
    pix_en = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
